// File: rtl/exe_stage.sv
// exe_stage: execute stage of the 5-stage MIPS pipeline.
// Registers the decoded bundle from decode, computes the ALU result, issues the
// data SRAM request and forwards the result bundle to the memory stage. The stage
// always completes in one cycle, so it only stalls when memory cannot accept.
module exe_stage #(
    parameter int DS_TO_ES_BUS_WD = 136,
    parameter int ES_TO_MS_BUS_WD = 71
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       ms_allowin,
    output logic                       es_allowin,
    input  logic                       ds_to_es_valid,
    input  logic [DS_TO_ES_BUS_WD-1:0] ds_to_es_bus,
    output logic                       es_to_ms_valid,
    output logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
    output logic                       data_sram_en,
    output logic [3:0]                 data_sram_wen,
    output logic [31:0]                data_sram_addr,
    output logic [31:0]                data_sram_wdata
);

    // One-hot ALU operation positions inside alu_op.
    localparam int OP_ADD  = 0;
    localparam int OP_SUB  = 1;
    localparam int OP_SLT  = 2;
    localparam int OP_SLTU = 3;
    localparam int OP_AND  = 4;
    localparam int OP_NOR  = 5;
    localparam int OP_OR   = 6;
    localparam int OP_XOR  = 7;
    localparam int OP_SLL  = 8;
    localparam int OP_SRL  = 9;
    localparam int OP_SRA  = 10;
    localparam int OP_LUI  = 11;

    // Pipeline control and bundle registers.
    logic                       es_valid_q;
    logic                       es_valid_d;
    logic [DS_TO_ES_BUS_WD-1:0] es_bus_q;
    logic [DS_TO_ES_BUS_WD-1:0] es_bus_d;
    logic                       es_ready_go;

    // Fields of the registered bundle.
    logic [11:0] es_alu_op;
    logic        es_load_op;
    logic        es_src1_is_sa;
    logic        es_src1_is_pc;
    logic        es_src2_is_imm;
    logic        es_src2_is_8;
    logic        es_gr_we;
    logic        es_mem_we;
    logic [4:0]  es_dest;
    logic [15:0] es_imm;
    logic [31:0] es_rs_value;
    logic [31:0] es_rt_value;
    logic [31:0] es_pc;

    // Operands and per-operation results.
    logic signed [31:0] src1;
    logic signed [31:0] src2;
    logic        [4:0]  shamt;
    logic        [31:0] add_res;
    logic        [31:0] sub_res;
    logic        [31:0] slt_res;
    logic        [31:0] sltu_res;
    logic        [31:0] logic_res;
    logic        [31:0] shift_res;
    logic        [31:0] lui_res;
    logic        [31:0] alu_result;

    // Replicate a select bit across a word so results can be OR-merged.
    function automatic logic [31:0] gate(input logic sel, input logic [31:0] val);
        return {32{sel}} & val;
    endfunction

    // Barrel shifter covering sll/srl/sra; at most one select is set.
    function automatic logic [31:0] shifter(input logic               do_sll,
                                            input logic               do_srl,
                                            input logic               do_sra,
                                            input logic signed [31:0] val,
                                            input logic        [4:0]  amt);
        logic [31:0] sll_v;
        logic [31:0] srl_v;
        logic [31:0] sra_v;
        sll_v = val << amt;
        srl_v = $unsigned(val) >> amt;
        sra_v = val >>> amt;
        return gate(do_sll, sll_v) | gate(do_srl, srl_v) | gate(do_sra, sra_v);
    endfunction

    // ---- Handshake ----
    assign es_ready_go    = 1'b1;
    assign es_allowin     = !es_valid_q || (es_ready_go && ms_allowin);
    assign es_to_ms_valid = es_valid_q && es_ready_go;

    // Next-state: valid follows decode whenever we can accept; the bundle only loads on a real handshake.
    always_comb begin
        es_valid_d = es_valid_q;
        es_bus_d   = es_bus_q;
        if (es_allowin) begin
            es_valid_d = ds_to_es_valid;
        end
        if (ds_to_es_valid && es_allowin) begin
            es_bus_d = ds_to_es_bus;
        end
    end

    // Stage register; both control and bundle clear asynchronously so every output is quiet under reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            es_valid_q <= 1'b0;
            es_bus_q   <= '0;
        end else begin
            es_valid_q <= es_valid_d;
            es_bus_q   <= es_bus_d;
        end
    end

    // ---- Decode -> execute boundary: unpack the registered bundle ----
    assign es_alu_op      = es_bus_q[135:124];
    assign es_load_op     = es_bus_q[123];
    assign es_src1_is_sa  = es_bus_q[122];
    assign es_src1_is_pc  = es_bus_q[121];
    assign es_src2_is_imm = es_bus_q[120];
    assign es_src2_is_8   = es_bus_q[119];
    assign es_gr_we       = es_bus_q[118];
    assign es_mem_we      = es_bus_q[117];
    assign es_dest        = es_bus_q[116:112];
    assign es_imm         = es_bus_q[111:96];
    assign es_rs_value    = es_bus_q[95:64];
    assign es_rt_value    = es_bus_q[63:32];
    assign es_pc          = es_bus_q[31:0];

    // Operand select: shift amount field, PC (for link) or rs; sign-extended immediate, 8 (link offset) or rt.
    always_comb begin
        src1 = es_rs_value;
        if (es_src1_is_sa) begin
            src1 = {27'b0, es_imm[10:6]};
        end else if (es_src1_is_pc) begin
            src1 = es_pc;
        end
        src2 = es_rt_value;
        if (es_src2_is_imm) begin
            src2 = {{16{es_imm[15]}}, es_imm};
        end else if (es_src2_is_8) begin
            src2 = 32'd8;
        end
    end

    assign shamt = src1[4:0];

    // ALU: every operation is evaluated in parallel and the one-hot alu_op picks the result.
    always_comb begin
        add_res   = src1 + src2;
        sub_res   = src1 - src2;
        slt_res   = {31'b0, (src1 < src2)};
        sltu_res  = {31'b0, ($unsigned(src1) < $unsigned(src2))};
        logic_res = gate(es_alu_op[OP_AND], src1 & src2)
                  | gate(es_alu_op[OP_NOR], ~(src1 | src2))
                  | gate(es_alu_op[OP_OR],  src1 | src2)
                  | gate(es_alu_op[OP_XOR], src1 ^ src2);
        shift_res = shifter(es_alu_op[OP_SLL], es_alu_op[OP_SRL], es_alu_op[OP_SRA], src2, shamt);
        lui_res   = {src2[15:0], 16'b0};
        alu_result = gate(es_alu_op[OP_ADD],  add_res)
                   | gate(es_alu_op[OP_SUB],  sub_res)
                   | gate(es_alu_op[OP_SLT],  slt_res)
                   | gate(es_alu_op[OP_SLTU], sltu_res)
                   | logic_res
                   | shift_res
                   | gate(es_alu_op[OP_LUI],  lui_res);
    end

    // ---- Execute -> memory boundary: SRAM request and result bundle ----
    // A stalled store simply keeps asserting the same write, which is harmless to repeat.
    assign data_sram_en    = es_valid_q && (es_load_op || es_mem_we);
    assign data_sram_wen   = (es_valid_q && es_mem_we) ? 4'hf : 4'h0;
    assign data_sram_addr  = alu_result;
    assign data_sram_wdata = es_rt_value;

    assign es_to_ms_bus = {es_load_op, es_gr_we, es_dest, alu_result, es_pc};

endmodule
